instruction_fetcher: RTL and testbench

- Per-core fetch unit that produces the 16-bit `instruction` consumed by the core's decode stage.
- On the scheduler's FETCH state it reads the word at `current_pc` from program memory over a valid/ready read channel, holds it stable through DECODE, and reports progress to the scheduler via `fetcher_state`.
- A one-entry last-fetch buffer skips the memory access when the same PC is re-fetched (tight branch-to-self loops, waits). Saturating counters expose fetch and miss totals.

---
 rtl/instruction_fetcher.sv | 138 +++++++++++++
 tb/tb_instruction_fetcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: per-core fetch unit. It reads the instruction at
// current_pc over a valid/ready channel when the scheduler is in FETCH, and
// keeps it stable through DECODE. A one-entry last-fetch buffer serves
// re-fetches of the same PC without a memory access. Saturating counters
// track completed fetches and memory-served fetches.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      fetch_count,
    output logic [15:0]                      miss_count
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } fetch_state_t;

    // Last-fetch buffer entry: tag is the full PC, no partial matching.
    typedef struct packed {
        logic                             valid;
        logic [PROGRAM_MEM_ADDR_BITS-1:0] tag;
        logic [PROGRAM_MEM_DATA_BITS-1:0] data;
    } fetch_buf_t;

    fetch_state_t                     state_q, state_d;
    logic                             req_valid_q, req_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    fetch_buf_t                       buf_q, buf_d;
    logic [15:0]                      fetch_cnt_q, fetch_cnt_d;
    logic [15:0]                      miss_cnt_q, miss_cnt_d;
    logic                             fetch_inc, miss_inc;
    logic                             hit;

    // Lookup uses the registered buffer, so a same-cycle invalidate does not
    // affect this cycle's hit decision.
    assign hit = buf_q.valid && (buf_q.tag == current_pc);

    // Next-state and next-output logic for the fetch FSM and its side state.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        instr_d     = instr_q;
        buf_d       = buf_q;
        fetch_inc   = 1'b0;
        miss_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (hit) begin
                        instr_d   = buf_q.data;
                        fetch_inc = 1'b1;
                        state_d   = S_FETCHED;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = current_pc;
                        state_d     = S_FETCHING;
                    end
                end
            end
            S_FETCHING: begin
                // Request holds until memory answers; no timeout by design.
                if (mem_read_ready) begin
                    instr_d     = mem_read_data;
                    req_valid_d = 1'b0;
                    buf_d.valid = 1'b1;
                    buf_d.tag   = req_addr_q;
                    buf_d.data  = mem_read_data;
                    fetch_inc   = 1'b1;
                    miss_inc    = 1'b1;
                    state_d     = S_FETCHED;
                end
            end
            S_FETCHED: begin
                if (core_state == CORE_DECODE)
                    state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        // Invalidate wins over a same-cycle fill.
        if (invalidate)
            buf_d.valid = 1'b0;

        fetch_cnt_d = (fetch_inc && (fetch_cnt_q != 16'hFFFF)) ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
        miss_cnt_d  = (miss_inc  && (miss_cnt_q  != 16'hFFFF)) ? miss_cnt_q  + 16'd1 : miss_cnt_q;
    end

    // State register; synchronous reset clears everything, including the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            instr_q     <= '0;
            buf_q       <= '0;
            fetch_cnt_q <= 16'd0;
            miss_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            buf_q       <= buf_d;
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = req_valid_q;
    assign mem_read_address = req_addr_q;
    assign instruction      = instr_q;
    assign fetch_count      = fetch_cnt_q;
    assign miss_count       = miss_cnt_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Testbench for instruction_fetcher: per-cycle vector table plus hand-written
// sequences for reset mid-fetch and counter saturation.
module tb_instruction_fetcher;

    localparam logic [2:0] CF = 3'b001; // FETCH
    localparam logic [2:0] CD = 3'b010; // DECODE
    localparam logic [2:0] CO = 3'b000; // other
    localparam logic [2:0] IDL = 3'b000, FTG = 3'b001, FTD = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        invalidate;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] fetch_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16)) dut (
        .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
        .invalidate(invalidate), .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
        .instruction(instruction), .fetch_count(fetch_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cs;
        logic [7:0]  pc;
        logic        inv;
        logic        rdy;
        logic [15:0] data;
        logic [2:0]  st;
        logic        vld;
        logic [7:0]  addr;
        logic [15:0] ins;
        logic [15:0] fc;
        logic [15:0] mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic [2:0] cs, logic [7:0] pc, logic inv, logic rdy,
                               logic [15:0] data, logic [2:0] st, logic vld, logic [7:0] addr,
                               logic [15:0] ins, logic [15:0] fc, logic [15:0] mc);
        vec_t r;
        r.cs = cs; r.pc = pc; r.inv = inv; r.rdy = rdy; r.data = data;
        r.st = st; r.vld = vld; r.addr = addr; r.ins = ins; r.fc = fc; r.mc = mc;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are applied right after a falling edge; outputs are sampled at
    // the next falling edge, i.e. after exactly one rising edge.
    task automatic step(logic [2:0] cs, logic [7:0] pc, logic inv, logic rdy, logic [15:0] data);
        core_state = cs; current_pc = pc; invalidate = inv;
        mem_read_ready = rdy; mem_read_data = data;
        @(negedge clk);
    endtask

    task automatic expect_all(string tag, logic [2:0] st, logic vld, logic [7:0] addr,
                              logic [15:0] ins, logic [15:0] fc, logic [15:0] mc);
        chk({tag, " state"}, 32'(fetcher_state), 32'(st));
        chk({tag, " valid"}, 32'(mem_read_valid), 32'(vld));
        chk({tag, " addr"},  32'(mem_read_address), 32'(addr));
        chk({tag, " instr"}, 32'(instruction), 32'(ins));
        chk({tag, " fcnt"},  32'(fetch_count), 32'(fc));
        chk({tag, " mcnt"},  32'(miss_count), 32'(mc));
    endtask

    initial begin
        //                cs  pc    inv rdy data      st   vld addr  ins       fc  mc
        // basic miss: request high exactly 3 cycles, answer 16'h3123
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h0000, 0, 0));
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h0000, 0, 0));
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h0000, 0, 0));
        vecs.push_back(v(CF, 8'h05, 0, 1, 16'h3123, FTD, 0, 8'h05, 16'h3123, 1, 1));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h3123, 1, 1));
        // re-fetch hit
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTD, 0, 8'h05, 16'h3123, 2, 1));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h3123, 2, 1));
        // different PC, zero-wait answer
        vecs.push_back(v(CF, 8'h06, 0, 0, 16'h0000, FTG, 1, 8'h06, 16'h3123, 2, 1));
        vecs.push_back(v(CF, 8'h06, 0, 1, 16'h9A07, FTD, 0, 8'h06, 16'h9A07, 3, 2));
        vecs.push_back(v(CD, 8'h06, 0, 0, 16'h0000, IDL, 0, 8'h06, 16'h9A07, 3, 2));
        // PC 05 now misses: buffer holds 06
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h9A07, 3, 2));
        vecs.push_back(v(CF, 8'h05, 0, 1, 16'h3123, FTD, 0, 8'h05, 16'h3123, 4, 3));
        // stray ready in FETCHED, then in IDLE: ignored
        vecs.push_back(v(CO, 8'h05, 0, 1, 16'hBEEF, FTD, 0, 8'h05, 16'h3123, 4, 3));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h3123, 4, 3));
        vecs.push_back(v(CO, 8'h00, 0, 1, 16'hDEAD, IDL, 0, 8'h05, 16'h3123, 4, 3));
        // invalidate pulse, then same PC misses
        vecs.push_back(v(CO, 8'h05, 1, 0, 16'h0000, IDL, 0, 8'h05, 16'h3123, 4, 3));
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h3123, 4, 3));
        // invalidate coincident with capture: capture and counts happen, buffer stays empty
        vecs.push_back(v(CF, 8'h05, 1, 1, 16'h3123, FTD, 0, 8'h05, 16'h3123, 5, 4));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h3123, 5, 4));
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h3123, 5, 4));
        vecs.push_back(v(CF, 8'h05, 0, 1, 16'h4444, FTD, 0, 8'h05, 16'h4444, 6, 5));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h4444, 6, 5));
        // invalidate coincident with hit check: still a hit, next one misses
        vecs.push_back(v(CF, 8'h05, 1, 0, 16'h0000, FTD, 0, 8'h05, 16'h4444, 7, 5));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h4444, 7, 5));
        vecs.push_back(v(CF, 8'h05, 0, 0, 16'h0000, FTG, 1, 8'h05, 16'h4444, 7, 5));
        vecs.push_back(v(CF, 8'h05, 0, 1, 16'h5555, FTD, 0, 8'h05, 16'h5555, 8, 6));
        vecs.push_back(v(CD, 8'h05, 0, 0, 16'h0000, IDL, 0, 8'h05, 16'h5555, 8, 6));
        // full-width tag: 8'h85 differs from 8'h05 only in the MSB
        vecs.push_back(v(CF, 8'h85, 0, 0, 16'h0000, FTG, 1, 8'h85, 16'h5555, 8, 6));
        vecs.push_back(v(CF, 8'h85, 0, 1, 16'h6666, FTD, 0, 8'h85, 16'h6666, 9, 7));
        // non-DECODE code keeps FETCHED
        vecs.push_back(v(CF, 8'h85, 0, 0, 16'h0000, FTD, 0, 8'h85, 16'h6666, 9, 7));
        vecs.push_back(v(CD, 8'h85, 0, 0, 16'h0000, IDL, 0, 8'h85, 16'h6666, 9, 7));

        reset = 1'b1;
        core_state = CO; current_pc = 8'h00; invalidate = 1'b0;
        mem_read_ready = 1'b0; mem_read_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        expect_all("reset", IDL, 0, 8'h00, 16'h0000, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].cs, vecs[i].pc, vecs[i].inv, vecs[i].rdy, vecs[i].data);
            expect_all($sformatf("v%0d", i), vecs[i].st, vecs[i].vld, vecs[i].addr,
                       vecs[i].ins, vecs[i].fc, vecs[i].mc);
        end

        // reset while FETCHING, with a ready in the reset cycle
        step(CF, 8'h10, 0, 0, 16'h0000);
        expect_all("pre_rst", FTG, 1, 8'h10, 16'h6666, 9, 7);
        reset = 1'b1;
        step(CF, 8'h10, 0, 1, 16'h7777);
        expect_all("mid_rst", IDL, 0, 8'h00, 16'h0000, 0, 0);
        reset = 1'b0;
        // buffer cleared by reset: previously buffered PC misses
        step(CF, 8'h85, 0, 0, 16'h0000);
        expect_all("rst_miss", FTG, 1, 8'h85, 16'h0000, 0, 0);
        step(CF, 8'h85, 0, 1, 16'h6666);
        expect_all("rst_fill", FTD, 0, 8'h85, 16'h6666, 1, 1);
        step(CD, 8'h85, 0, 0, 16'h0000);

        // saturation: preload both counters to FFFE while idle
        force dut.fetch_cnt_q = 16'hFFFE;
        force dut.miss_cnt_q  = 16'hFFFE;
        step(CO, 8'h85, 0, 0, 16'h0000);
        release dut.fetch_cnt_q;
        release dut.miss_cnt_q;
        step(CO, 8'h85, 0, 0, 16'h0000);
        expect_all("preload", IDL, 0, 8'h85, 16'h6666, 16'hFFFE, 16'hFFFE);
        step(CF, 8'h85, 0, 0, 16'h0000);
        expect_all("sat_hit1", FTD, 0, 8'h85, 16'h6666, 16'hFFFF, 16'hFFFE);
        step(CD, 8'h85, 0, 0, 16'h0000);
        step(CF, 8'h85, 0, 0, 16'h0000);
        expect_all("sat_hit2", FTD, 0, 8'h85, 16'h6666, 16'hFFFF, 16'hFFFE);
        step(CD, 8'h85, 0, 0, 16'h0000);
        step(CF, 8'h40, 0, 0, 16'h0000);
        step(CF, 8'h40, 0, 1, 16'h1234);
        expect_all("sat_miss1", FTD, 0, 8'h40, 16'h1234, 16'hFFFF, 16'hFFFF);
        step(CD, 8'h40, 0, 0, 16'h0000);
        step(CF, 8'h41, 0, 0, 16'h0000);
        step(CF, 8'h41, 0, 1, 16'h4321);
        expect_all("sat_miss2", FTD, 0, 8'h41, 16'h4321, 16'hFFFF, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
